// File: rtl/mem_port_pkg.sv
// Shared types and constants for the fixed-latency memory port.
package mem_port_pkg;
  typedef enum logic [1:0] {MP_IDLE, MP_BUSY, MP_RESP} mem_port_state_t;
  localparam int MP_MAX_LATENCY = 15;
  localparam int MP_WORD_W      = 32;
endpackage

// File: rtl/mem_port_ram.sv
// Single-port DEPTH x 32 storage with write enable and a read register that
// only loads on a read, so the last load value persists across stores.
// No reset: contents and the read register survive reset.
module mem_port_ram
  import mem_port_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        idx,
  input  logic [MP_WORD_W-1:0] wdata,
  output logic [MP_WORD_W-1:0] rdata
);
  logic [MP_WORD_W-1:0] mem [DEPTH];

  // Synchronous write and registered, enabled read.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/mem_latency_port.sv
// Fixed-latency word memory with a valid/ready request and a one-cycle
// response pulse. One request is outstanding at a time.
// Optional build macro MEM_LATENCY_PORT_ALIGN_CHECK_EN: misaligned requests
// skip the array access and report resp_err during the response cycle.
module mem_latency_port
  import mem_port_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  generate
    if (LATENCY < 1 || LATENCY > MP_MAX_LATENCY || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $fatal(1, "mem_latency_port: illegal LATENCY or DEPTH");
    end
  endgenerate

  mem_port_state_t state;
  logic [CNT_W-1:0] cnt;
  logic             cap_write;
  logic [AW-1:0]    cap_idx;
  logic [1:0]       cap_lo;
  logic [31:0]      cap_wdata;
  logic             have_load;

  logic             accept, enter_resp, cur_write, mis;
  logic [AW-1:0]    cur_idx;
  logic [1:0]       cur_lo;
  logic [31:0]      cur_wdata, ram_q;
  logic             ram_we, ram_re;
  logic             unused_addr;

  assign unused_addr = &{1'b0, req_addr[31:AW+2], req_addr[1:0], cur_lo};

  // With LATENCY==1 the access happens on the accepting edge, so the array
  // sees the live request; otherwise it sees the captured copy.
  assign accept     = (state == MP_IDLE) && req_valid;
  assign cur_write  = accept ? req_write           : cap_write;
  assign cur_idx    = accept ? req_addr[AW+1:2]    : cap_idx;
  assign cur_lo     = accept ? req_addr[1:0]       : cap_lo;
  assign cur_wdata  = accept ? req_wdata           : cap_wdata;
  assign enter_resp = (accept && LATENCY == 1) || (state == MP_BUSY && cnt == '0);

`ifdef MEM_LATENCY_PORT_ALIGN_CHECK_EN
  assign mis = (cur_lo != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Gate with reset so an async reset on an access edge never touches the array.
  assign ram_we = enter_resp && cur_write  && !mis && !reset;
  assign ram_re = enter_resp && !cur_write && !mis && !reset;

  mem_port_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  // The read register has no reset; have_load masks it to zero until the
  // first load after reset completes.
  assign resp_rdata = have_load ? ram_q : 32'h0;

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MP_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      have_load  <= 1'b0;
      cap_write  <= 1'b0;
      cap_idx    <= '0;
      cap_lo     <= '0;
      cap_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (enter_resp) begin
        state      <= MP_RESP;
        req_ready  <= 1'b0;
        resp_valid <= 1'b1;
        resp_err   <= mis;
        if (ram_re) have_load <= 1'b1;
      end
      case (state)
        MP_IDLE: if (req_valid) begin
          cap_write <= req_write;
          cap_idx   <= req_addr[AW+1:2];
          cap_lo    <= req_addr[1:0];
          cap_wdata <= req_wdata;
          req_ready <= 1'b0;
          if (LATENCY != 1) begin
            cnt   <= CNT_INIT;
            state <= MP_BUSY;
          end
        end
        MP_BUSY: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        MP_RESP: begin
          state     <= MP_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= MP_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_latency_port.sv
// Directed bench: instance 0 has LATENCY=3, instance 1 has LATENCY=1.
module tb_mem_latency_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  valid = '0, write = '0, ready, rvalid, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_latency_port #(.LATENCY(3), .DEPTH(1024)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(valid[0]), .req_write(write[0]),
    .req_addr(addr[0]), .req_wdata(wdata[0]), .req_ready(ready[0]),
    .resp_valid(rvalid[0]), .resp_rdata(rdata[0]), .resp_err(err[0]));

  mem_latency_port #(.LATENCY(1), .DEPTH(1024)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(valid[1]), .req_write(write[1]),
    .req_addr(addr[1]), .req_wdata(wdata[1]), .req_ready(ready[1]),
    .resp_valid(rvalid[1]), .resp_rdata(rdata[1]), .resp_err(err[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request on instance w; checks ready timing and response latency.
  task automatic txn(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input int lat, output logic [31:0] rd, output logic er);
    int n;
    bit got;
    rd = 'x; er = 'x; n = 0; got = 0;
    @(negedge clk);
    chk("ready_before", {31'b0, ready[w]}, 32'd1);
    valid[w] = 1'b1; write[w] = wr; addr[w] = a; wdata[w] = d;
    @(posedge clk); #1 valid[w] = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (ready[w]) chk("ready_low", {31'b0, ready[w]}, 32'd0);
      if (rvalid[w]) begin got = 1; n = i; rd = rdata[w]; er = err[w]; end
    end
    chk("latency", n, lat);
    @(negedge clk);
    chk("pulse_once", {31'b0, rvalid[w]}, 32'd0);
    chk("ready_back", {31'b0, ready[w]}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          cnt, last;

  initial begin
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_ready", {31'b0, ready[w]}, 32'd1);
      chk("rst_rvalid", {31'b0, rvalid[w]}, 32'd0);
      chk("rst_rdata", rdata[w], 32'd0);
      chk("rst_err", {31'b0, err[w]}, 32'd0);
    end

    // LATENCY=3: preload mem[4] then load 0x10
    txn(0, 1, 32'h10, 32'hDEADBEEF, 3, rd, er);
    chk("l3_store_err", {31'b0, er}, 32'd0);
    txn(0, 0, 32'h10, 32'h0, 3, rd, er);
    chk("l3_load", rd, 32'hDEADBEEF);

    // LATENCY=1: address wrap, then store/load with rdata hold
    txn(1, 1, 32'h1000, 32'hA5A5A5A5, 1, rd, er);
    txn(1, 0, 32'h0, 32'h0, 1, rd, er);
    chk("wrap_load", rd, 32'hA5A5A5A5);
    txn(1, 1, 32'h20, 32'h12345678, 1, rd, er);
    chk("hold_on_store", rd, 32'hA5A5A5A5);
    txn(1, 0, 32'h20, 32'h0, 1, rd, er);
    chk("l1_load", rd, 32'h12345678);

    // Misaligned store to 0x22
    txn(1, 1, 32'h22, 32'h2468ACE0, 1, rd, er);
`ifdef MEM_LATENCY_PORT_ALIGN_CHECK_EN
    chk("mis_err", {31'b0, er}, 32'd1);
    chk("mis_rdata_hold", rd, 32'h12345678);
    txn(1, 0, 32'h20, 32'h0, 1, rd, er);
    chk("mis_mem8", rd, 32'h12345678);
`else
    chk("mis_err", {31'b0, er}, 32'd0);
    txn(1, 0, 32'h20, 32'h0, 1, rd, er);
    chk("mis_mem8", rd, 32'h2468ACE0);
`endif

    // req_valid held high on LATENCY=3: one accept every 4 cycles
    @(negedge clk);
    valid[0] = 1'b1; write[0] = 1'b0; addr[0] = 32'h10;
    cnt = 0; last = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (rvalid[0]) begin
        cnt++;
        if (cnt == 1) chk("stream_first", i, 3);
        else chk("stream_gap", i - last, 4);
        last = i;
      end
    end
    valid[0] = 1'b0;
    chk("stream_count", cnt, 4);
    @(negedge clk);

    // Reset one cycle after accepting a store: discarded, no response
    txn(0, 1, 32'h8, 32'h11111111, 3, rd, er);
    @(negedge clk);
    valid[0] = 1'b1; write[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hFFFFFFFF;
    @(posedge clk); #1 valid[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rvalid[0]) cnt++;
    end
    chk("rst_rdata_zero", rdata[0], 32'd0);
    chk("rst_ready_mid", {31'b0, ready[0]}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rvalid[0]) cnt++;
    end
    chk("rst_no_resp", cnt, 0);
    txn(0, 0, 32'h8, 32'h0, 3, rd, er);
    chk("rst_store_discarded", rd, 32'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
